// File: rtl/truth_table_sequencer.sv
// Clocked self-test sequencer: sweeps a combinational expression through every
// input vector, captures its truth table and scores it against an expected table.
module truth_table_sequencer #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [(1<<N_IN)-1:0] expected_i,
    input  logic                 s_in_i,
    output logic [N_IN-1:0]      x_out_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [(1<<N_IN)-1:0] table_o,
    output logic [N_IN:0]        mismatch_count_o,
    output logic                 pass_o
);

    localparam int unsigned NV = 1 << N_IN;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [3:0]      WAIT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [1:0]      ST_VEC    = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
    localparam logic [N_IN-1:0] LAST_IDX  = '1;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic [N_IN-1:0] x_q, x_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NV-1:0]   table_q, table_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d;

    logic            miss;
    logic [N_IN:0]   cnt_inc;

    assign miss    = s_in_i ^ exp_q[idx_q];
    assign cnt_inc = cnt_q + (N_IN+1)'(miss);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        exp_d   = exp_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    exp_d   = expected_i;
                    idx_d   = '0;
                    x_d     = '0;
                    table_d = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = WAIT_INIT;
                    state_d = ST_VEC;
                end
            end
            ST_SETTLE: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = s_in_i;
                cnt_d          = cnt_inc;
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_inc == '0);
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    x_d     = idx_q + 1'b1;
                    wait_d  = WAIT_INIT;
                    state_d = ST_VEC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            exp_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            exp_q   <= exp_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign x_out_o          = x_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign table_o          = table_q;
    assign mismatch_count_o = cnt_q;
    assign pass_o           = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: default build (SETTLE=1) and a SETTLE=0 build,
// each driving a truth function held in the bench and checked against a table model.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] expected_a, expected_b;
    logic [7:0] func;

    logic [2:0] x_a, x_b;
    logic       s_a, s_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] table_a, table_b;
    logic [3:0] cnt_a, cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    // The "expression block": S is a lookup of the current function by input vector.
    assign s_a = func[x_a];
    assign s_b = func[x_b];

    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .start_i(start_a), .expected_i(expected_a),
        .s_in_i(s_a), .x_out_o(x_a), .busy_o(busy_a), .done_o(done_a),
        .table_o(table_a), .mismatch_count_o(cnt_a), .pass_o(pass_a)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(0)) dut_b (
        .clk(clk), .reset(reset), .start_i(start_b), .expected_i(expected_b),
        .s_in_i(s_b), .x_out_o(x_b), .busy_o(busy_b), .done_o(done_b),
        .table_o(table_b), .mismatch_count_o(cnt_b), .pass_o(pass_b)
    );

    function automatic int unsigned popc(input logic [7:0] v);
        int unsigned c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // S = (x + y')' . z'
    function automatic logic [7:0] expr_table();
        logic [7:0] t;
        logic [2:0] b;
        for (int i = 0; i < 8; i++) begin
            b    = 3'(i);
            t[i] = !(b[2] || !b[1]) && !b[0];
        end
        return t;
    endfunction

    function automatic logic [2:0] vec_after(input int unsigned k, input int unsigned s);
        int unsigned v = k / (s + 1);
        return (v > 7) ? 3'd7 : 3'(v);
    endfunction

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        expected_a = '0; expected_b = '0; func = expr_table();
        #12;
        n_checks++;
        if ({x_a, busy_a, done_a, table_a, cnt_a, pass_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got x=%0d busy=%b done=%b table=%h cnt=%0d pass=%b, want all 0",
                     x_a, busy_a, done_a, table_a, cnt_a, pass_a);
        end
        n_checks++;
        if ({x_b, busy_b, done_b, table_b, cnt_b, pass_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got x=%0d busy=%b done=%b table=%h cnt=%0d pass=%b, want all 0",
                     x_b, busy_b, done_b, table_b, cnt_b, pass_b);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One full sweep on the SETTLE=1 build; optionally changes expected and pulses start at edge 6.
    task automatic test_sweep(input logic [7:0] exp_v, input logic [7:0] fn, input bit disturb);
        int unsigned k;
        bit          seen;
        int unsigned want_cnt;
        func = fn; expected_a = exp_v;
        want_cnt = popc(fn ^ exp_v);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || x_a !== 3'd0) begin
            n_fail++;
            $display("FAIL start_edge: got busy=%b x=%0d, want busy=1 x=0", busy_a, x_a);
        end
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            if (disturb && k == 6) begin start_a = 1'b1; expected_a = ~exp_v; end
            if (disturb && k == 7) start_a = 1'b0;
            @(posedge clk); #1;
            k++;
            seen = done_a;
            n_checks++;
            if (x_a !== vec_after(k, 1)) begin
                n_fail++;
                $display("FAIL x_step: edge %0d got x=%0d, want %0d", k, x_a, vec_after(k, 1));
            end
            if (!seen && busy_a !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL busy_hold: edge %0d got busy=%b, want 1", k, busy_a);
            end
        end
        n_checks++;
        if (!seen || k != 16) begin
            n_fail++;
            $display("FAIL done_latency: got done at edge %0d (seen=%0d), want 16", k, seen);
        end
        n_checks++;
        if (table_a !== fn || cnt_a !== 4'(want_cnt) || pass_a !== (want_cnt == 0) || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL result: got table=%h cnt=%0d pass=%b busy=%b, want table=%h cnt=%0d pass=%b busy=0",
                     table_a, cnt_a, pass_a, busy_a, fn, want_cnt, want_cnt == 0);
        end
        expected_a = 8'h5A;
        @(posedge clk); #1;
        n_checks++;
        if (done_a !== 1'b0 || table_a !== fn || cnt_a !== 4'(want_cnt) || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got done=%b table=%h cnt=%0d busy=%b, want done=0 table=%h cnt=%0d busy=0",
                     done_a, table_a, cnt_a, busy_a, fn, want_cnt);
        end
    endtask

    task automatic test_reset_mid();
        func = expr_table(); expected_a = 8'h04;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({x_a, busy_a, done_a, table_a, cnt_a, pass_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got x=%0d busy=%b done=%b table=%h cnt=%0d pass=%b, want all 0",
                     x_a, busy_a, done_a, table_a, cnt_a, pass_a);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 2) reset = 1'b0;
            if (done_a !== 1'b0) begin
                n_checks++; n_fail++;
                $display("FAIL reset_no_done: cycle %0d got done=%b, want 0", i, done_a);
            end
        end
        test_sweep(8'h04, expr_table(), 1'b0);
    endtask

    task automatic test_settle0(input logic [7:0] exp_v, input logic [7:0] fn);
        int unsigned k;
        bit          seen;
        int unsigned want_cnt;
        func = fn; expected_b = exp_v;
        want_cnt = popc(fn ^ exp_v);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 30) begin
            @(posedge clk); #1;
            k++;
            seen = done_b;
            n_checks++;
            if (x_b !== vec_after(k, 0)) begin
                n_fail++;
                $display("FAIL s0_x_step: edge %0d got x=%0d, want %0d", k, x_b, vec_after(k, 0));
            end
        end
        n_checks++;
        if (!seen || k != 8) begin
            n_fail++;
            $display("FAIL s0_latency: got done at edge %0d (seen=%0d), want 8", k, seen);
        end
        n_checks++;
        if (table_b !== fn || cnt_b !== 4'(want_cnt) || pass_b !== (want_cnt == 0)) begin
            n_fail++;
            $display("FAIL s0_result: got table=%h cnt=%0d pass=%b, want table=%h cnt=%0d pass=%b",
                     table_b, cnt_b, pass_b, fn, want_cnt, want_cnt == 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int unsigned k;
        bit          seen;
        func = expr_table(); expected_a = 8'h04;
        start_a = 1'b1;
        @(posedge clk); #1;
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1; k++; seen = done_a;
        end
        n_checks++;
        if (!seen || k != 16 || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got done edge %0d seen=%0d pass=%b, want 16 1 1", k, seen, pass_a);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || table_a !== 8'h00 || x_a !== 3'd0 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got done=%b busy=%b table=%h x=%0d pass=%b, want 0 1 00 0 0",
                     done_a, busy_a, table_a, x_a, pass_a);
        end
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1; k++; seen = done_a;
        end
        n_checks++;
        if (!seen || k != 16 || table_a !== 8'h04 || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got done edge %0d seen=%0d table=%h pass=%b, want 16 1 04 1",
                     k, seen, table_a, pass_a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rf, re;
        test_reset();
        test_sweep(8'h04, expr_table(), 1'b0);
        test_sweep(8'h05, expr_table(), 1'b0);
        test_sweep(8'hFB, expr_table(), 1'b0);
        test_sweep(8'h04, expr_table(), 1'b1);
        for (int i = 0; i < 4; i++) begin
            rf = 8'($urandom);
            re = (i == 0) ? rf : 8'($urandom);
            test_sweep(re, rf, 1'b0);
        end
        test_reset_mid();
        test_settle0(8'h04, expr_table());
        for (int i = 0; i < 3; i++) begin
            rf = 8'($urandom);
            re = 8'($urandom);
            test_settle0(re, rf);
        end
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
